// File: rtl/ex3_pkg.sv
// rtl/ex3_pkg.sv - shared excess-3 constants, code check and adder state type
//
// Purpose : constants and helpers used by the excess-3 serial adder slice.
// Contents: EX3_OFFSET / EX3_MIN / EX3_MAX, ex3_legal(code), ex3_state_e.
package ex3_pkg;

    localparam logic [3:0] EX3_OFFSET = 4'd3;
    localparam logic [3:0] EX3_MIN    = 4'd3;
    localparam logic [3:0] EX3_MAX    = 4'd12;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } ex3_state_e;

    function automatic logic ex3_legal(input logic [3:0] code);
        return (code >= EX3_MIN) && (code <= EX3_MAX);
    endfunction

endpackage

// File: rtl/ex3_serial_adder_if.sv
// rtl/ex3_serial_adder_if.sv - digit-pair input stream and sum-digit output stream
//
// Purpose : bundles both handshakes of the serial adder.
// Ports   : in_valid/in_ready/a_ex3/b_ex3/in_last  digit pair stream (LSD first)
//           out_valid/out_ready/sum_ex3/out_last   sum digit stream
//           carry_out/err                          per-number status on out_last
// Modports: master = producer/consumer side, slave = the adder.
interface ex3_serial_adder_if;

    logic       in_valid;
    logic       in_ready;
    logic [3:0] a_ex3;
    logic [3:0] b_ex3;
    logic       in_last;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] sum_ex3;
    logic       out_last;
    logic       carry_out;
    logic       err;

    modport master (
        output in_valid, a_ex3, b_ex3, in_last, out_ready,
        input  in_ready, out_valid, sum_ex3, out_last, carry_out, err
    );

    modport slave (
        input  in_valid, a_ex3, b_ex3, in_last, out_ready,
        output in_ready, out_valid, sum_ex3, out_last, carry_out, err
    );

endinterface

// File: rtl/ex3_digit_add.sv
// rtl/ex3_digit_add.sv - combinational single-digit excess-3 adder
//
// Purpose : adds two excess-3 digits plus carry-in, re-biases the result.
// Ports   : a, b   excess-3 digits (raw bits, legality not checked here)
//           cin    decimal carry in
//           digit  excess-3 sum digit
//           cout   decimal carry out
module ex3_digit_add
    import ex3_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] digit,
    output logic       cout
);

    logic [4:0] s;

    // Two biased operands carry a bias of 6; a binary overflow past 16 is
    // exactly a decimal carry, so the correction is +3 on carry, -3 otherwise.
    always_comb begin
        s = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
        if (s[4]) begin
            digit = s[3:0] + EX3_OFFSET;
            cout  = 1'b1;
        end else begin
            digit = s[3:0] - EX3_OFFSET;
            cout  = 1'b0;
        end
    end

endmodule

// File: rtl/ex3_serial_adder.sv
// rtl/ex3_serial_adder.sv - digit-serial excess-3 adder with registered output
//
// Purpose : accepts one excess-3 digit pair per beat (LSD first), emits the
//           excess-3 sum digit stream, final decimal carry and a sticky error.
// Ports   : clk       rising-edge clock
//           rst       asynchronous active-high reset
//           bus       ex3_serial_adder_if.slave (both streams + status)
// Params  : MAX_DIGITS  digits per number before a forced last (overrun)
module ex3_serial_adder
    import ex3_pkg::*;
#(
    parameter int MAX_DIGITS = 8
) (
    input  logic               clk,
    input  logic               rst,
    ex3_serial_adder_if.slave  bus
);

    localparam int             CW         = $clog2(MAX_DIGITS + 1);
    localparam logic [CW-1:0]  LAST_COUNT = CW'(MAX_DIGITS - 1);

    ex3_state_e     state_q;
    ex3_state_e     state_next;
    logic           carry_q;
    logic [CW-1:0]  count_q;
    logic           err_q;

    logic           cin;
    logic [CW-1:0]  count_base;
    logic           err_base;

    logic           accept;
    logic           illegal;
    logic           overrun;
    logic           is_last;
    logic           err_num;
    logic [3:0]     digit;
    logic           cout;

    logic           out_valid_q;
    logic [3:0]     sum_q;
    logic           out_last_q;
    logic           carry_out_q;
    logic           err_out_q;

    assign bus.in_ready  = !out_valid_q || bus.out_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.sum_ex3   = sum_q;
    assign bus.out_last  = out_last_q;
    assign bus.carry_out = carry_out_q;
    assign bus.err       = err_out_q;

    assign accept  = bus.in_valid && bus.in_ready;
    assign illegal = !ex3_legal(bus.a_ex3) || !ex3_legal(bus.b_ex3);
    // The beat that fills the last digit slot without in_last closes the number.
    assign overrun = !bus.in_last && (count_base == LAST_COUNT);
    assign is_last = bus.in_last || overrun;
    assign err_num = err_base || illegal || overrun;

    ex3_digit_add u_digit_add (
        .a     (bus.a_ex3),
        .b     (bus.b_ex3),
        .cin   (cin),
        .digit (digit),
        .cout  (cout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_next;
        end
    end

    always_comb begin
        state_next = state_q;
        if (accept) begin
            state_next = is_last ? IDLE : RUN;
        end
    end

    // A number always starts from a clean carry/count/error in IDLE.
    always_comb begin
        cin        = 1'b0;
        count_base = '0;
        err_base   = 1'b0;
        if (state_q == RUN) begin
            cin        = carry_q;
            count_base = count_q;
            err_base   = err_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            carry_q <= 1'b0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else if (accept) begin
            if (is_last) begin
                carry_q <= 1'b0;
                count_q <= '0;
                err_q   <= 1'b0;
            end else begin
                carry_q <= cout;
                count_q <= count_base + CW'(1);
                err_q   <= err_num;
            end
        end
    end

    // Output stage reloads on push (including simultaneous pop) and holds on stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            sum_q       <= EX3_OFFSET;
            out_last_q  <= 1'b0;
            carry_out_q <= 1'b0;
            err_out_q   <= 1'b0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            sum_q       <= digit;
            out_last_q  <= is_last;
            carry_out_q <= is_last && cout;
            err_out_q   <= is_last && err_num;
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ex3_serial_adder.sv
// tb/tb_ex3_serial_adder.sv - self-checking bench for ex3_serial_adder
module tb_ex3_serial_adder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    ex3_serial_adder_if bus();

    ex3_serial_adder #(.MAX_DIGITS(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drives one beat, lets it be accepted, then checks the registered output.
    task automatic beat(input string tag, input logic [3:0] a, input logic [3:0] b,
                        input logic last, input logic [3:0] exp_sum,
                        input logic exp_last, input logic exp_co, input logic exp_err);
        bus.in_valid = 1'b1;
        bus.a_ex3    = a;
        bus.b_ex3    = b;
        bus.in_last  = last;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        chk({tag, ".valid"}, 32'(bus.out_valid), 32'd1);
        chk({tag, ".sum"},   32'(bus.sum_ex3),   32'(exp_sum));
        chk({tag, ".last"},  32'(bus.out_last),  32'(exp_last));
        chk({tag, ".carry"}, 32'(bus.carry_out), 32'(exp_co));
        chk({tag, ".err"},   32'(bus.err),       32'(exp_err));
    endtask

    initial begin
        int          da[8];
        int          db[8];
        int          len;
        longint      av;
        longint      bv;
        longint      sv;
        longint      p;
        logic [3:0]  held;

        bus.in_valid  = 1'b0;
        bus.a_ex3     = 4'd3;
        bus.b_ex3     = 4'd3;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;

        // Reset state
        #12;
        chk("rst.valid", 32'(bus.out_valid), 32'd0);
        chk("rst.sum",   32'(bus.sum_ex3),   32'd3);
        chk("rst.last",  32'(bus.out_last),  32'd0);
        chk("rst.carry", 32'(bus.carry_out), 32'd0);
        chk("rst.err",   32'(bus.err),       32'd0);
        chk("rst.ready", 32'(bus.in_ready),  32'd1);
        @(negedge clk);
        rst = 1'b0;

        // 25 + 38 = 63
        beat("d25_0", 4'd8,  4'd11, 1'b0, 4'd6, 1'b0, 1'b0, 1'b0);
        beat("d25_1", 4'd5,  4'd6,  1'b1, 4'd9, 1'b1, 1'b0, 1'b0);

        // 99 + 01 = 100
        beat("d99_0", 4'd12, 4'd4,  1'b0, 4'd3, 1'b0, 1'b0, 1'b0);
        beat("d99_1", 4'd12, 4'd3,  1'b1, 4'd3, 1'b1, 1'b1, 1'b0);

        // Illegal code: raw arithmetic, error reported only on the final digit
        beat("ill_0", 4'hF,  4'd3,  1'b0, 4'd5, 1'b0, 1'b0, 1'b0);
        beat("ill_1", 4'd3,  4'd3,  1'b1, 4'd4, 1'b1, 1'b0, 1'b1);
        beat("ill_n", 4'd4,  4'd4,  1'b1, 4'd5, 1'b1, 1'b0, 1'b0);

        // Backpressure mid-stream: 147 + 258 = 405
        beat("bp_0", 4'd10, 4'd11, 1'b0, 4'd8, 1'b0, 1'b0, 1'b0);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.a_ex3     = 4'd7;
        bus.b_ex3     = 4'd8;
        bus.in_last   = 1'b0;
        #1;
        chk("bp.ready0", 32'(bus.in_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("bp.stall%0d.ready", i), 32'(bus.in_ready),  32'd0);
            chk($sformatf("bp.stall%0d.valid", i), 32'(bus.out_valid), 32'd1);
            chk($sformatf("bp.stall%0d.sum", i),   32'(bus.sum_ex3),   32'd8);
            chk($sformatf("bp.stall%0d.last", i),  32'(bus.out_last),  32'd0);
        end
        bus.out_ready = 1'b1;
        beat("bp_1", 4'd7, 4'd8, 1'b0, 4'd3, 1'b0, 1'b0, 1'b0);
        beat("bp_2", 4'd4, 4'd5, 1'b1, 4'd7, 1'b1, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        chk("bp.drain", 32'(bus.out_valid), 32'd0);

        // Overrun: eight digits without in_last
        for (int i = 0; i < 8; i++) begin
            beat($sformatf("ovr_%0d", i), 4'd3, 4'd3, 1'b0, 4'd3,
                 (i == 7), 1'b0, (i == 7));
        end
        beat("ovr_new", 4'd3, 4'd3, 1'b1, 4'd3, 1'b1, 1'b0, 1'b0);

        // Randomized legal numbers against a decimal reference
        for (int n = 0; n < 8; n++) begin
            len = (n == 0) ? 8 : int'($urandom_range(1, 8));
            av = 0;
            bv = 0;
            p  = 1;
            for (int i = 0; i < len; i++) begin
                da[i] = int'($urandom_range(0, 9));
                db[i] = int'($urandom_range(0, 9));
                av += longint'(da[i]) * p;
                bv += longint'(db[i]) * p;
                p  *= 10;
            end
            sv = av + bv;
            p  = 1;
            for (int i = 0; i < len; i++) begin
                held = 4'((sv / p) % 10 + 3);
                beat($sformatf("rnd%0d_%0d", n, i), 4'(da[i] + 3), 4'(db[i] + 3),
                     (i == len - 1), held, (i == len - 1),
                     (i == len - 1) && ((sv / (p * 10)) != 0), 1'b0);
                p *= 10;
                if ($urandom_range(0, 3) == 0) begin
                    @(posedge clk);
                    #1;
                    chk($sformatf("rnd%0d_%0d.gap", n, i), 32'(bus.out_valid), 32'd0);
                end
            end
        end

        // Reset mid-number discards the partial sum
        beat("rm_0", 4'd4, 4'd5, 1'b0, 4'd6, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        chk("rm.valid", 32'(bus.out_valid), 32'd0);
        chk("rm.sum",   32'(bus.sum_ex3),   32'd3);
        chk("rm.last",  32'(bus.out_last),  32'd0);
        chk("rm.ready", 32'(bus.in_ready),  32'd1);
        @(negedge clk);
        rst = 1'b0;
        beat("rm_new", 4'd7, 4'd8, 1'b1, 4'd12, 1'b1, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
